// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared encodings and types for the load/store initiator.
// Size codes, FSM states, the response record and the request legality rule.
package lsu_mem_ctrl_pkg;

  localparam int LSU_DW = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_RD  = 3'd1,
    LD_DAT = 3'd2,
    ST_WR  = 3'd3,
    RMW_RD = 3'd4,
    RMW_WR = 3'd5,
    ERR    = 3'd6
  } lsu_state_e;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [LSU_DW-1:0] rdata;
  } lsu_resp_t;

  // Illegal size code or natural-alignment violation.
  function automatic logic req_bad(lsu_size_e size, logic [1:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return |off;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and data_mem bus of the load/store initiator.
// slave = the controller, master = execute stage plus memory.
interface lsu_mem_ctrl_if #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 32
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [1:0]         req_size;
  logic               req_unsigned;
  logic [A_WIDTH-1:0] req_addr;
  logic [D_WIDTH-1:0] req_wdata;
  logic               resp_valid;
  logic               resp_err;
  logic [D_WIDTH-1:0] resp_rdata;
  logic               mem_we;
  logic [A_WIDTH-1:0] mem_w_addr;
  logic [D_WIDTH-1:0] mem_w_data;
  logic               mem_re;
  logic [A_WIDTH-1:0] mem_r_addr;
  logic [D_WIDTH-1:0] mem_r_data;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_r_data,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_we, mem_w_addr, mem_w_data, mem_re, mem_r_addr
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_r_data,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_we, mem_w_addr, mem_w_data, mem_re, mem_r_addr
  );
endinterface

// File: rtl/lsu_lane_fmt.sv
// Little-endian lane formatting: load extract/extend and byte/half store merge.
// Purely combinational; fixed 32-bit word with four byte lanes.
module lsu_lane_fmt
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  lsu_size_e   size,
  input  logic        uns,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);
  logic [31:0] sh;
  logic [15:0] hw;
  logic [31:0] mask;
  logic [31:0] rep;

  always_comb begin
    sh      = word >> {off, 3'b000};
    hw      = off[1] ? word[31:16] : word[15:0];
    ld_data = word;
    mask    = '1;
    rep     = wdata;
    case (size)
      SIZE_B: begin
        ld_data = uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        mask    = 32'h0000_00ff << {off, 3'b000};
        rep     = {4{wdata[7:0]}};
      end
      SIZE_H: begin
        ld_data = uns ? {16'b0, hw} : {{16{hw[15]}}, hw};
        mask    = off[1] ? 32'hffff_0000 : 32'h0000_ffff;
        rep     = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    // Replicated data lands in every lane; the mask keeps only the target lane(s).
    st_word = (word & ~mask) | (rep & mask);
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between execute and word-only data_mem.
// One request at a time; byte/half stores use read-modify-write.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  lsu_mem_ctrl_if.slave bus
);
  lsu_state_e         state_q, state_d;
  logic               we_q, we_d;
  lsu_size_e          size_q, size_d;
  logic               uns_q, uns_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic [D_WIDTH-1:0] wdata_q, wdata_d;
  lsu_resp_t          resp_q, resp_d;
  logic [31:0]        ld_data, st_word;

  lsu_lane_fmt u_fmt (
    .word    (bus.mem_r_data),
    .wdata   (wdata_q),
    .off     (addr_q[1:0]),
    .size    (size_q),
    .uns     (uns_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  assign bus.mem_w_addr = {addr_q[A_WIDTH-1:2], 2'b00};
  assign bus.mem_r_addr = {addr_q[A_WIDTH-1:2], 2'b00};
  assign bus.resp_valid = resp_q.valid;
  assign bus.resp_err   = resp_q.err;
  assign bus.resp_rdata = resp_q.rdata;

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    size_d         = size_q;
    uns_d          = uns_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    resp_d         = '0;
    bus.req_ready  = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_re     = 1'b0;
    bus.mem_w_data = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = lsu_size_e'(bus.req_size);
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (req_bad(lsu_size_e'(bus.req_size), bus.req_addr[1:0])) state_d = ERR;
          else if (!bus.req_we)                                     state_d = LD_RD;
          else if (lsu_size_e'(bus.req_size) == SIZE_W)             state_d = ST_WR;
          else                                                      state_d = RMW_RD;
        end
      end
      LD_RD: begin
        bus.mem_re = 1'b1;
        state_d    = LD_DAT;
      end
      LD_DAT: begin
        resp_d.valid = 1'b1;
        resp_d.rdata = ld_data;
        state_d      = IDLE;
      end
      ST_WR: begin
        bus.mem_we     = 1'b1;
        bus.mem_w_data = wdata_q;
        resp_d.valid   = 1'b1;
        state_d        = IDLE;
      end
      RMW_RD: begin
        bus.mem_re = 1'b1;
        state_d    = RMW_WR;
      end
      RMW_WR: begin
        // Old word arrives this cycle from the RMW_RD read.
        bus.mem_we     = 1'b1;
        bus.mem_w_data = st_word;
        resp_d.valid   = 1'b1;
        state_d        = IDLE;
      end
      ERR: begin
        resp_d.valid = 1'b1;
        resp_d.err   = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, reset/queue sequences and
// random traffic against a word-array reference model.
module tb_lsu_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.D_WIDTH(32), .A_WIDTH(32)) bus ();
  lsu_mem_ctrl #(.D_WIDTH(32), .A_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // data_mem model: 64 words, wraps on index, read data one cycle after re.
  logic [31:0] mem  [64];
  logic [31:0] rmem [64];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    if (bus.mem_we) mem[bus.mem_w_addr[7:2]] <= bus.mem_w_data;
    if (bus.mem_re) bus.mem_r_data <= mem[bus.mem_r_addr[7:2]];
  end

  int we_cnt = 0, re_cnt = 0, resp_cnt = 0, bad_cnt = 0;
  always @(posedge clk) begin
    if (bus.mem_we) we_cnt <= we_cnt + 1;
    if (bus.mem_re) re_cnt <= re_cnt + 1;
    if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
    if ((bus.mem_we && bus.mem_re) ||
        (bus.mem_we && bus.mem_w_addr[1:0] != 2'b00) ||
        (bus.mem_re && bus.mem_r_addr[1:0] != 2'b00) ||
        (!bus.resp_valid && (bus.resp_err || bus.resp_rdata != 32'h0)))
      bad_cnt <= bad_cnt + 1;
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    pre_we = 1'b1; pre_idx = idx[5:0]; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    rmem[idx] = d;
  endtask

  // Reference: legality, lane extraction and merge straight from the byte-lane rules.
  task automatic ref_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rdata,
                        output int lat, output int nwe, output int nre);
    int k, idx, nbytes;
    logic [31:0] w, val;
    k = int'(addr[1:0]); idx = int'(addr[7:2]); w = rmem[idx];
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || (k % nbytes != 0);
    rdata = 32'h0; lat = 1; nwe = 0; nre = 0;
    if (err) return;
    if (!we) begin
      lat = 2; nre = 1;
      val = 32'h0;
      for (int b = 0; b < nbytes; b++) val[8*b +: 8] = w[8*(k+b) +: 8];
      if (!uns && nbytes < 4 && val[8*nbytes-1])
        for (int b = nbytes; b < 4; b++) val[8*b +: 8] = 8'hff;
      rdata = val;
    end else begin
      nwe = 1;
      if (nbytes < 4) begin lat = 2; nre = 1; end
      for (int b = 0; b < nbytes; b++) w[8*(k+b) +: 8] = wdata[8*b +: 8];
      rmem[idx] = w;
    end
  endtask

  task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wdata;
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rdata,
                         output int lat, output int nwe, output int nre);
    int n, we0, re0;
    @(negedge clk);
    set_req(we, size, uns, addr, wdata);
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    we0 = we_cnt; re0 = re_cnt;
    lat = -1; err = 1'bx; rdata = 'x;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) begin lat = c; err = bus.resp_err; rdata = bus.resp_rdata; break; end
    end
    nwe = we_cnt - we0; nre = re_cnt - re0;
    @(posedge clk); #1;
    check("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic apply(input string nm, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic e_err, input logic [31:0] e_rd, input int e_lat,
                       input int e_nwe, input int e_nre);
    logic err; logic [31:0] rd; int lat, nwe, nre;
    run_req(we, size, uns, addr, wdata, err, rd, lat, nwe, nre);
    check({nm, ".err"},   32'(err),   32'(e_err));
    check({nm, ".rdata"}, rd,         e_rd);
    check({nm, ".lat"},   32'(lat),   32'(e_lat));
    check({nm, ".nwe"},   32'(nwe),   32'(e_nwe));
    check({nm, ".nre"},   32'(nre),   32'(e_nre));
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat, e_nwe, e_nre;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic e_err; logic [31:0] e_rd; int e_lat, e_nwe, e_nre;
    int we0, re0, resp0, accepts, busy_ready;
    logic [31:0] q_addr [4];
    logic [31:0] q_data [4];
    logic [1:0]  q_size [4];

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,       32'hdeadbeef, 1'b0, 32'h0,        1, 1, 0};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        1'b0, 32'hdeadbeef, 2, 0, 1};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h21,       32'h000000aa, 1'b0, 32'h0,        2, 1, 1};
    vecs[3]  = '{1'b0, 2'd2, 1'b0, 32'h20,       32'h0,        1'b0, 32'h1122aa44, 2, 0, 1};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h32,       32'h0,        1'b0, 32'hffffffff, 2, 0, 1};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h32,       32'h0,        1'b0, 32'h000000ff, 2, 0, 1};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h32,       32'h0,        1'b0, 32'hffff80ff, 2, 0, 1};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h30,       32'h0,        1'b0, 32'h00007f01, 2, 0, 1};
    vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'h13,       32'h1234,     1'b1, 32'h0,        1, 0, 0};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h22,       32'h0,        1'b1, 32'h0,        1, 0, 0};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h40,       32'h0,        1'b1, 32'h0,        1, 0, 0};
    vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h12,       32'h0000beef, 1'b0, 32'h0,        2, 1, 1};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        1'b0, 32'hbeefbeef, 2, 0, 1};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 32'h13,       32'h0,        1'b0, 32'h000000be, 2, 0, 1};
    vecs[14] = '{1'b1, 2'd2, 1'b0, 32'hffffff50, 32'h01020304, 1'b0, 32'h0,        1, 1, 0};

    bus.req_valid = 1'b0;
    set_req(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 64; i++) poke(i, 32'h5a00_0000 + i * 32'h0001_0203);
    poke(8, 32'h11223344);
    poke(12, 32'h80ff7f01);

    check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst.resp_err",   32'(bus.resp_err),   32'd0);
    check("rst.resp_rdata", bus.resp_rdata,      32'd0);
    check("rst.mem_we",     32'(bus.mem_we),     32'd0);
    check("rst.mem_re",     32'(bus.mem_re),     32'd0);
    check("rst.req_ready",  32'(bus.req_ready),  32'd1);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      ref_op(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
             e_err, e_rd, e_lat, e_nwe, e_nre);
      apply($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
            vecs[i].wdata, vecs[i].e_err, vecs[i].e_rd, vecs[i].e_lat, vecs[i].e_nwe, vecs[i].e_nre);
    end
    check("wrap_store", mem[20], 32'h01020304);

    // Reset while a byte-store RMW is in its read cycle.
    @(negedge clk);
    set_req(1'b1, 2'd0, 1'b0, 32'h20, 32'h55);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    we0 = we_cnt;
    check("abort.in_rmw_rd", 32'(bus.mem_re), 32'd1);
    rst_n = 1'b0; #1;
    check("abort.re_low", 32'(bus.mem_re), 32'd0);
    check("abort.we_low", 32'(bus.mem_we), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("abort.no_write",  32'(we_cnt - we0),      32'd0);
    check("abort.word",      mem[8],                 rmem[8]);
    check("abort.ready",     32'(bus.req_ready),     32'd1);
    check("abort.no_resp",   32'(bus.resp_valid),    32'd0);

    // Four stores offered with req_valid held high.
    q_addr = '{32'h40, 32'h45, 32'h4a, 32'h4c};
    q_data = '{32'hcafe0001, 32'h00000077, 32'h00009999, 32'h12345678};
    q_size = '{2'd2, 2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 4; i++) ref_op(1'b1, q_size[i], 1'b0, q_addr[i], q_data[i], e_err, e_rd, e_lat, e_nwe, e_nre);
    @(negedge clk);
    we0 = we_cnt; re0 = re_cnt; resp0 = resp_cnt; accepts = 0; busy_ready = 0;
    set_req(1'b1, q_size[0], 1'b0, q_addr[0], q_data[0]);
    bus.req_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && accepts < 4; cyc++) begin
      if (bus.req_ready && (accepts - (resp_cnt - resp0)) > 0 && !bus.resp_valid) busy_ready++;
      if (bus.req_ready) begin
        @(posedge clk); #1;
        accepts++;
        if (accepts < 4) set_req(1'b1, q_size[accepts], 1'b0, q_addr[accepts], q_data[accepts]);
        else bus.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    for (int c = 0; c < 10 && (resp_cnt - resp0) < 4; c++) @(negedge clk);
    check("queue.accepts",    32'(accepts),          32'd4);
    check("queue.responses",  32'(resp_cnt - resp0), 32'd4);
    check("queue.writes",     32'(we_cnt - we0),     32'd4);
    check("queue.reads",      32'(re_cnt - re0),     32'd2);
    check("queue.busy_ready", 32'(busy_ready),       32'd0);
    for (int i = 16; i < 20; i++) check($sformatf("queue.mem%0d", i), mem[i], rmem[i]);

    // Random traffic against the reference model.
    for (int i = 0; i < 80; i++) begin
      logic we, uns; logic [1:0] size; logic [31:0] addr, wd;
      we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3)); addr = $urandom; wd = $urandom;
      ref_op(we, size, uns, addr, wd, e_err, e_rd, e_lat, e_nwe, e_nre);
      apply($sformatf("rnd%0d", i), we, size, uns, addr, wd, e_err, e_rd, e_lat, e_nwe, e_nre);
    end

    for (int i = 0; i < 64; i++) check($sformatf("final.mem%0d", i), mem[i], rmem[i]);
    check("bus_rules", 32'(bad_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
